// File: rtl/tx_packer_if.sv
// ---------------------------------------------------------------------------
// tx_packer_if
// Stream bundle around the tx_packer width converter.
//   din side  : 16-bit user/protocol stream (din, din_vld, din_sop, din_eop,
//               din_mod) with backpressure din_rdy.
//   dout side : 32-bit MAC stream (dout, dout_vld, dout_sop, dout_eop,
//               dout_mod, dout_err) with downstream dout_rdy.
// Modports:
//   master : the environment (drives din_*, dout_rdy; observes the rest)
//   slave  : the packer (consumes din_*, dout_rdy; drives din_rdy, dout_*)
// ---------------------------------------------------------------------------
interface tx_packer_if;
    logic [15:0] din;
    logic        din_vld;
    logic        din_sop;
    logic        din_eop;
    logic        din_mod;
    logic        din_rdy;

    logic [31:0] dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;
    logic [1:0]  dout_mod;
    logic        dout_err;
    logic        dout_rdy;

    modport master (
        output din, din_vld, din_sop, din_eop, din_mod, dout_rdy,
        input  din_rdy, dout, dout_vld, dout_sop, dout_eop, dout_mod, dout_err
    );

    modport slave (
        input  din, din_vld, din_sop, din_eop, din_mod, dout_rdy,
        output din_rdy, dout, dout_vld, dout_sop, dout_eop, dout_mod, dout_err
    );
endinterface

// File: rtl/tx_packer.sv
// ---------------------------------------------------------------------------
// tx_packer
// Packs a 16-bit packet stream into big-endian 32-bit words (first beat in
// [31:16]) and queues them in a show-ahead FIFO towards the MAC.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   s_if   : tx_packer_if.slave, din_* input stream and dout_* output stream
// Parameter:
//   DEPTH  : FIFO depth in 32-bit words (power of 2, >= 4)
// Build option:
//   TX_PACKER_ABORT_EN : a sop beat in the middle of a packet terminates the
//   open packet with an err-flagged eop word and starts a new packet.
//   Without it such a sop is treated as ordinary continuation data.
//
// state  | meaning
// S_IDLE | between packets, waiting for a sop beat
// S_HI   | in packet, next beat is the upper half of a word
// S_LO   | upper half held in r_hi, next beat completes the word
// S_ONE  | single-beat word held in r_one, waiting for FIFO space
// ---------------------------------------------------------------------------
module tx_packer #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    tx_packer_if.slave s_if
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_ONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_hi, w_hi_nxt;
    logic        r_hi_sop, w_hi_sop_nxt;
    logic [36:0] r_one, w_one_nxt;

    logic        w_push;
    logic [36:0] w_wdata;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_din_rdy;
    logic        w_acc;
    logic [36:0] w_head;

    logic [36:0] r_mem [DEPTH];
    logic [AW:0] r_wptr, r_rptr;

    // FIFO entry layout: {err, mod[1:0], eop, sop, data[31:0]}
    function automatic logic [36:0] f_entry(input logic        err,
                                            input logic [1:0]  mod,
                                            input logic        eop,
                                            input logic        sop,
                                            input logic [31:0] data);
        return {err, mod, eop, sop, data};
    endfunction

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_din_rdy = !w_full && (r_state != S_ONE);
    assign w_acc     = s_if.din_vld && w_din_rdy;
    assign w_pop     = !w_empty && s_if.dout_rdy;

    always_comb begin
        w_state_nxt  = r_state;
        w_hi_nxt     = r_hi;
        w_hi_sop_nxt = r_hi_sop;
        w_one_nxt    = r_one;
        w_push       = 1'b0;
        w_wdata      = '0;
        case (r_state)
            S_IDLE: begin
                // beats arriving outside a packet without sop are dropped
                if (w_acc && s_if.din_sop) begin
                    if (s_if.din_eop) begin
                        w_push  = 1'b1;
                        w_wdata = f_entry(1'b0, {1'b1, s_if.din_mod}, 1'b1, 1'b1,
                                          {s_if.din, 16'h0});
                    end else begin
                        w_hi_nxt     = s_if.din;
                        w_hi_sop_nxt = 1'b1;
                        w_state_nxt  = S_LO;
                    end
                end
            end
            S_HI: begin
                if (w_acc) begin
`ifdef TX_PACKER_ABORT_EN
                    if (s_if.din_sop) begin
                        // nothing of the open word is held: close with an empty word
                        w_push       = 1'b1;
                        w_wdata      = f_entry(1'b1, 2'd0, 1'b1, 1'b0, 32'h0);
                        w_hi_nxt     = s_if.din;
                        w_hi_sop_nxt = 1'b1;
                        w_one_nxt    = f_entry(1'b0, {1'b1, s_if.din_mod}, 1'b1, 1'b1,
                                               {s_if.din, 16'h0});
                        w_state_nxt  = s_if.din_eop ? S_ONE : S_LO;
                    end else
`endif
                    if (s_if.din_eop) begin
                        w_push      = 1'b1;
                        w_wdata     = f_entry(1'b0, {1'b1, s_if.din_mod}, 1'b1, 1'b0,
                                              {s_if.din, 16'h0});
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_hi_nxt     = s_if.din;
                        w_hi_sop_nxt = 1'b0;
                        w_state_nxt  = S_LO;
                    end
                end
            end
            S_LO: begin
                if (w_acc) begin
`ifdef TX_PACKER_ABORT_EN
                    if (s_if.din_sop) begin
                        // flush the held upper half as a truncated, corrupt eop word
                        w_push       = 1'b1;
                        w_wdata      = f_entry(1'b1, 2'd2, 1'b1, r_hi_sop,
                                               {r_hi, 16'h0});
                        w_hi_nxt     = s_if.din;
                        w_hi_sop_nxt = 1'b1;
                        w_one_nxt    = f_entry(1'b0, {1'b1, s_if.din_mod}, 1'b1, 1'b1,
                                               {s_if.din, 16'h0});
                        w_state_nxt  = s_if.din_eop ? S_ONE : S_LO;
                    end else
`endif
                    begin
                        w_push      = 1'b1;
                        w_wdata     = f_entry(1'b0,
                                              s_if.din_eop ? {1'b0, s_if.din_mod} : 2'd0,
                                              s_if.din_eop, r_hi_sop,
                                              {r_hi, s_if.din});
                        w_state_nxt = s_if.din_eop ? S_IDLE : S_HI;
                    end
                end
            end
            S_ONE: begin
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_wdata     = r_one;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_hi     <= '0;
            r_hi_sop <= 1'b0;
            r_one    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hi     <= w_hi_nxt;
            r_hi_sop <= w_hi_sop_nxt;
            r_one    <= w_one_nxt;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= w_wdata;
    end

    assign w_head = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    assign s_if.din_rdy  = w_din_rdy;
    assign s_if.dout     = w_head[31:0];
    assign s_if.dout_sop = w_head[32];
    assign s_if.dout_eop = w_head[33];
    assign s_if.dout_mod = w_head[35:34];
    assign s_if.dout_err = w_head[36];
    assign s_if.dout_vld = !w_empty;
endmodule

// File: tb/tb_tx_packer.sv
// ---------------------------------------------------------------------------
// tb_tx_packer
// Directed bench for tx_packer. Expected output words are queued as the
// stimulus is driven and checked in order as the DUT hands words downstream.
// Expectations for the mid-packet sop cases follow TX_PACKER_ABORT_EN.
// ---------------------------------------------------------------------------
module tb_tx_packer;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [36:0] q[$];
    logic [36:0] m_obs;
    logic [36:0] m_exp;

    tx_packer_if u_if ();

    tx_packer #(.DEPTH(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_if  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [36:0] ew(input logic [31:0] d, input logic s,
                                       input logic e, input logic [1:0] m,
                                       input logic r);
        return {r, m, e, s, d};
    endfunction

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst_n && u_if.dout_vld && u_if.dout_rdy) begin
                m_obs = {u_if.dout_err, u_if.dout_mod, u_if.dout_eop,
                         u_if.dout_sop, u_if.dout};
                tests++;
                assert (q.size() != 0)
                else begin
                    fails++;
                    $error("FAIL unexpected_word observed=%h expected=none", m_obs);
                end
                if (q.size() != 0) begin
                    m_exp = q.pop_front();
                    tests++;
                    assert (m_obs === m_exp)
                    else begin
                        fails++;
                        $error("FAIL out_word observed=%h expected=%h", m_obs, m_exp);
                    end
                end
            end
        end
    endtask

    // Drive one beat at posedge+1 and hold it until accepted.
    task automatic send(input logic [15:0] d, input logic s, input logic e, input logic m);
        int n;
        u_if.din     = d;
        u_if.din_sop = s;
        u_if.din_eop = e;
        u_if.din_mod = m;
        u_if.din_vld = 1'b1;
        n = 0;
        while (u_if.din_rdy !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        assert (n < 2000)
        else begin
            fails++;
            $error("FAIL send_timeout observed=%0d cycles expected=<2000", n);
        end
        @(posedge clk); #1;
        u_if.din_vld = 1'b0;
        u_if.din_sop = 1'b0;
        u_if.din_eop = 1'b0;
        u_if.din_mod = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        assert (q.size() == 0)
        else begin
            fails++;
            $error("FAIL drain observed=%0d pending expected=0", q.size());
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        u_if.din      = '0;
        u_if.din_vld  = 1'b0;
        u_if.din_sop  = 1'b0;
        u_if.din_eop  = 1'b0;
        u_if.din_mod  = 1'b0;
        u_if.dout_rdy = 1'b1;
        fork
            monitor_loop();
        join_none
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        chk("rst_vld",  {36'h0, u_if.dout_vld}, 37'h0);
        chk("rst_dout", {5'h0, u_if.dout},      37'h0);
        chk("rst_sop",  {36'h0, u_if.dout_sop}, 37'h0);
        chk("rst_eop",  {36'h0, u_if.dout_eop}, 37'h0);
        chk("rst_mod",  {35'h0, u_if.dout_mod}, 37'h0);
        chk("rst_err",  {36'h0, u_if.dout_err}, 37'h0);
        chk("rst_rdy",  {36'h0, u_if.din_rdy},  37'h1);

        // four-beat packet
        q.push_back(ew(32'h11112222, 1'b1, 1'b0, 2'd0, 1'b0));
        q.push_back(ew(32'h33334444, 1'b0, 1'b1, 2'd0, 1'b0));
        send(16'h1111, 1'b1, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 1'b0, 1'b0);
        send(16'h3333, 1'b0, 1'b0, 1'b0);
        send(16'h4444, 1'b0, 1'b1, 1'b0);
        wait_drain();

        // three-beat packet ending on a half-filled beat
        q.push_back(ew(32'hAAAABBBB, 1'b1, 1'b0, 2'd0, 1'b0));
        q.push_back(ew(32'hCC000000, 1'b0, 1'b1, 2'd3, 1'b0));
        send(16'hAAAA, 1'b1, 1'b0, 1'b0);
        send(16'hBBBB, 1'b0, 1'b0, 1'b0);
        send(16'hCC00, 1'b0, 1'b1, 1'b1);
        wait_drain();

        // beat outside a packet is dropped, then single-beat packet latency
        send(16'hDEAD, 1'b0, 1'b0, 1'b0);
        q.push_back(ew(32'h5A5A0000, 1'b1, 1'b1, 2'd2, 1'b0));
        send(16'h5A5A, 1'b1, 1'b1, 1'b0);
        chk("single_lat_vld", {36'h0, u_if.dout_vld}, 37'h1);
        chk("single_lat_dat", {5'h0, u_if.dout},      {5'h0, 32'h5A5A0000});
        wait_drain();

        // backpressure: 16 words fill the FIFO, din_rdy must drop
        u_if.dout_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            q.push_back(ew({16'h1000 + 16'(2*i), 16'h1000 + 16'(2*i+1)},
                           i == 0, i == 19, 2'd0, 1'b0));
        end
        for (int i = 0; i < 32; i++) begin
            send(16'h1000 + 16'(i), i == 0, 1'b0, 1'b0);
        end
        chk("full_rdy",  {36'h0, u_if.din_rdy}, 37'h0);
        chk("full_head", {5'h0, u_if.dout},     {5'h0, 32'h10001001});
        repeat (3) @(posedge clk);
        #1;
        chk("full_rdy_hold", {36'h0, u_if.din_rdy}, 37'h0);
        u_if.dout_rdy = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_pop", {36'h0, u_if.din_rdy}, 37'h1);
        for (int i = 32; i < 40; i++) begin
            send(16'h1000 + 16'(i), 1'b0, i == 39, 1'b0);
        end
        wait_drain();

        // sop arriving while the upper half is held
        q.push_back(ew(32'h11112222, 1'b1, 1'b0, 2'd0, 1'b0));
`ifdef TX_PACKER_ABORT_EN
        q.push_back(ew(32'h33330000, 1'b0, 1'b1, 2'd2, 1'b1));
        q.push_back(ew(32'h77778888, 1'b1, 1'b1, 2'd0, 1'b0));
`else
        q.push_back(ew(32'h33337777, 1'b0, 1'b0, 2'd0, 1'b0));
        q.push_back(ew(32'h88880000, 1'b0, 1'b1, 2'd2, 1'b0));
`endif
        send(16'h1111, 1'b1, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 1'b0, 1'b0);
        send(16'h3333, 1'b0, 1'b0, 1'b0);
        send(16'h7777, 1'b1, 1'b0, 1'b0);
        send(16'h8888, 1'b0, 1'b1, 1'b0);
        wait_drain();

        // sop+eop arriving at a word boundary inside a packet
        q.push_back(ew(32'h11112222, 1'b1, 1'b0, 2'd0, 1'b0));
`ifdef TX_PACKER_ABORT_EN
        q.push_back(ew(32'h00000000, 1'b0, 1'b1, 2'd0, 1'b1));
        q.push_back(ew(32'hAAAA0000, 1'b1, 1'b1, 2'd3, 1'b0));
`else
        q.push_back(ew(32'hAAAA0000, 1'b0, 1'b1, 2'd3, 1'b0));
`endif
        send(16'h1111, 1'b1, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 1'b0, 1'b0);
        send(16'hAAAA, 1'b1, 1'b1, 1'b1);
        wait_drain();

        // reset with five words queued and a half word held
        u_if.dout_rdy = 1'b0;
        for (int i = 0; i < 11; i++) begin
            send(16'h2000 + 16'(i), i == 0, 1'b0, 1'b0);
        end
        chk("pre_rst_vld", {36'h0, u_if.dout_vld}, 37'h1);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("in_rst_vld",  {36'h0, u_if.dout_vld}, 37'h0);
        chk("in_rst_dout", {5'h0, u_if.dout},      37'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        u_if.dout_rdy = 1'b1;
        chk("post_rst_rdy", {36'h0, u_if.din_rdy}, 37'h1);
        send(16'h9999, 1'b0, 1'b0, 1'b0);
        q.push_back(ew(32'h44445555, 1'b1, 1'b0, 2'd0, 1'b0));
        q.push_back(ew(32'h66660000, 1'b0, 1'b1, 2'd3, 1'b0));
        send(16'h4444, 1'b1, 1'b0, 1'b0);
        send(16'h5555, 1'b0, 1'b0, 1'b0);
        send(16'h6666, 1'b0, 1'b1, 1'b1);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("final_empty", {36'h0, u_if.dout_vld}, 37'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tx_packer.md
# tx_packer

Transmit-side width converter for the UDP/IP datapath. It accepts the 16-bit packet stream (sop/eop/vld/1-bit mod) produced by the user and protocol logic, packs beat pairs big-endian into 32-bit words, and buffers them in an internal FIFO. It drives the 32-bit MAC-side stream (sop/eop/vld/2-bit mod/err) with valid/ready flow control, and performs the exact inverse of the receive-side 32→16 unpacking.

## Interface
- DEPTH, 16: output FIFO depth in 32-bit words; power of 2, ≥4.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  16  input half-word; first byte in [15:8].
- din_vld  in  1  input beat valid.
- din_sop  in  1  first beat of packet.
- din_eop  in  1  last beat of packet.
- din_mod  in  1  on eop beat: 1 = only din[15:8] valid.
- din_rdy  out  1  beat accepted when din_vld && din_rdy.
- dout  out  32  output word; first byte in [31:24].
- dout_vld  out  1  FIFO head valid.
- dout_sop  out  1  head is first word of packet.
- dout_eop  out  1  head is last word of packet.
- dout_mod  out  2  on eop word: number of invalid trailing bytes (0–3).
- dout_err  out  1  on eop word: packet is corrupt, must be dropped downstream.
- dout_rdy  in  1  downstream pops head when dout_vld && dout_rdy.

## Operation
- Packer FSM, states S_IDLE, S_HI (in packet, expecting upper half), S_LO (upper half held in hi_reg), S_ONE (single-beat word pending). Each cycle writes at most one FIFO entry {err,mod,eop,sop,data}, 37 bits.
- S_IDLE, accepted beat:
  - without sop: discarded, stay.
  - sop && eop: write {din,16'h0}, sop=eop=1, mod=2+din_mod; stay.
  - sop only: hi_reg←din, hi_sop←1; → S_LO.
- S_HI, accepted non-sop beat: eop → write {din,16'h0}, eop=1, mod=2+din_mod, → S_IDLE; else hi_reg←din, hi_sop←0, → S_LO.
- S_LO, accepted non-sop beat: write {hi_reg,din}, sop=hi_sop, eop=din_eop, mod=din_eop?din_mod:0; → S_IDLE if eop else S_HI.
- Mid-packet sop (S_HI/S_LO): see Configuration.
- din_rdy = !fifo_full && state≠S_ONE (combinational).
- S_ONE: when !fifo_full, write held single-beat word, → S_IDLE.
- FIFO: show-ahead; dout_* are the head entry fields. When empty, dout_vld=0 and all dout_* are 0. Simultaneous push and pop permitted at any fill level; push never occurs when full.
- dout_err is 0 on every word unless the Configuration feature sets it.

## Timing
- Reset: state S_IDLE, hi_reg=0, FIFO empty; dout=0, dout_vld/sop/eop/err=0, dout_mod=0, din_rdy=1 in the first cycle after release. Reset mid-packet discards partial word and all queued words.
- Latency: the word completed by the beat accepted on edge t appears at dout with dout_vld=1 in the cycle after t (FIFO previously empty).
- Throughput: one output word per two input beats; sustained input rate one beat/cycle with dout_rdy=1.
- din_rdy falls in the cycle the FIFO reaches DEPTH entries; rises in the cycle after a pop.
- Word order is strictly input order; no reordering, no loss while din_rdy honoured.

## Configuration
- TX_PACKER_ABORT_EN defined: a sop beat in S_HI or S_LO aborts the current packet. S_LO: write {hi_reg,16'h0}, eop=1, err=1, mod=2. S_HI: write 32'h0, eop=1, err=1, mod=0. The sop beat is consumed as a new packet: hi_reg←din, hi_sop←1, → S_LO; if also eop, the single-beat word is held → S_ONE.
- Undefined: din_sop ignored outside S_IDLE; the beat is processed as ordinary continuation data. dout_err is constant 0.

## Test plan
- 4 beats 1111,2222,3333,4444 (sop first, eop last, mod=0) → 0x11112222 sop; 0x33334444 eop mod=0.
- 3 beats AAAA,BBBB,CC00 with eop mod=1 → 0xAAAABBBB sop; 0xCC000000 eop mod=3.
- Single beat 5A5A sop+eop mod=0 → one cycle later 0x5A5A0000 sop=eop=1 mod=2.
- dout_rdy=0, stream 40 beats → din_rdy low after 16 words (32 beats) stored; release dout_rdy → all 20 words emitted in order, none lost.
- ABORT_EN on: 1111,2222,3333 then sop 7777 → 0x11112222 sop; 0x33330000 eop err=1 mod=2; new packet starting 0x7777…. Macro off: same stimulus → 0x11112222, 0x33337777 continuing one packet, err=0.
- Assert rst_n mid-packet with 5 words queued → dout_vld=0 immediately; next clean packet output correctly.
